mem_port_arbiter: RTL

Shares one single-port synchronous memory between the instruction-fetch stage and the load/store stage of the pipelined RISC-V core. The two requesters use a req/gnt/rvalid handshake. The block sequences each access through a fixed-latency memory. The LSU has priority over fetch, and an anti-starvation counter bounds how long fetch can wait. Exactly one access is outstanding at a time.

---
 rtl/mem_port_arbiter_if.sv | 61 ++++++
 rtl/mem_port_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch requester, load/store requester and single-port memory
// signals that meet at mem_port_arbiter.
//   slave  modport : the arbiter's view (requests and mem_rdata in; grants,
//                    responses, memory strobes and busy out)
//   master modport : the opposite view (requesters + memory side)
// Signals:
//   if_req/if_addr/if_gnt/if_rvalid/if_rdata              fetch port
//   ls_req/ls_we/ls_addr/ls_wdata/ls_be/ls_gnt/
//   ls_rvalid/ls_rdata                                    load/store port
//   mem_en/mem_we/mem_addr/mem_wdata/mem_be/mem_rdata     memory port
//   busy                                                  arbiter not idle
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int AW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [31:0]   if_rdata;

  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [31:0]   ls_wdata;
  logic [3:0]    ls_be;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [31:0]   ls_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr,
    input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    output busy
  );

  modport master (
    output if_req, if_addr,
    output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port, fixed-latency synchronous memory between the
// instruction-fetch stage and the load/store stage. One access is outstanding
// at a time; LSU has priority, but after STARVE_MAX consecutive LSU grants
// made while fetch was waiting, fetch is forced to win.
// Ports:
//   clk  : clock
//   rst  : synchronous, active-high reset (aborts any in-flight access)
//   bus  : mem_port_arbiter_if.slave (fetch, load/store and memory signals)
// Access sequence: IDLE (arbitrate) -> ISSUE (gnt + mem_en) -> WAIT
// (MEM_LAT cycles, the last one captures mem_rdata) -> RESP (rvalid).
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [2:0] LAST_WAIT  = 3'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e        state_q, state_d;
  logic          owner_ls_q, owner_ls_d;   // 0 = fetch owns the access
  logic          we_q, we_d;
  logic [AW-3:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [2:0]    wait_cnt_q, wait_cnt_d;
  logic [3:0]    starve_q, starve_d;

  logic          if_gnt_q, if_gnt_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic          ls_gnt_q, ls_gnt_d;
  logic          ls_rvalid_q, ls_rvalid_d;
  logic [31:0]   ls_rdata_q, ls_rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          busy_q, busy_d;

  logic          forced_s;

  // Byte-offset bits of the requester addresses carry no meaning here.
  logic unused_addr_lsb_s;
  assign unused_addr_lsb_s = ^{bus.if_addr[1:0], bus.ls_addr[1:0]};

  // Fetch must win once it has waited through STARVE_MAX LSU grants.
  assign forced_s = bus.if_req && (starve_q == STARVE_LIM);

  // Next-state, latched-access and next-output computation.
  always_comb begin
    state_d     = state_q;
    owner_ls_d  = owner_ls_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    wait_cnt_d  = wait_cnt_q;
    starve_d    = starve_q;
    if_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    if_rdata_d  = 32'd0;
    ls_gnt_d    = 1'b0;
    ls_rvalid_d = 1'b0;
    ls_rdata_d  = 32'd0;
    mem_en_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.ls_req && !forced_s) begin
          state_d    = S_ISSUE;
          owner_ls_d = 1'b1;
          we_d       = bus.ls_we;
          addr_d     = bus.ls_addr[AW-1:2];
          wdata_d    = bus.ls_wdata;
          be_d       = bus.ls_be;
          ls_gnt_d   = 1'b1;
          mem_en_d   = 1'b1;
          // forced_s is false here, so starve_q < STARVE_LIM whenever fetch waits
          if (bus.if_req) begin
            starve_d = starve_q + 4'd1;
          end else begin
            starve_d = starve_q;
          end
        end else if (bus.if_req) begin
          state_d    = S_ISSUE;
          owner_ls_d = 1'b0;
          we_d       = 1'b0;
          addr_d     = bus.if_addr[AW-1:2];
          wdata_d    = 32'd0;
          be_d       = 4'b1111;
          if_gnt_d   = 1'b1;
          mem_en_d   = 1'b1;
          starve_d   = 4'd0;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d    = S_WAIT;
        wait_cnt_d = 3'd0;
      end
      S_WAIT: begin
        // The final WAIT cycle is the one where mem_rdata is valid.
        if (wait_cnt_q == LAST_WAIT) begin
          state_d = S_RESP;
          if (owner_ls_q) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = we_q ? 32'd0 : bus.mem_rdata;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = bus.mem_rdata;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State, access latches and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_ls_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      wait_cnt_q  <= 3'd0;
      starve_q    <= 4'd0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'd0;
      ls_gnt_q    <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= 32'd0;
      mem_en_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_ls_q  <= owner_ls_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      wait_cnt_q  <= wait_cnt_d;
      starve_q    <= starve_d;
      if_gnt_q    <= if_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_gnt_q    <= ls_gnt_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
      mem_en_q    <= mem_en_d;
      busy_q      <= busy_d;
    end
  end

  // The access latches double as the held memory command outputs.
  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_gnt    = ls_gnt_q;
  assign bus.ls_rvalid = ls_rvalid_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.busy      = busy_q;

endmodule
